// File: rtl/multi_alarm_clock_core.sv
// BCD time-of-day core with NUM_ALARMS alarm slots and a ring/auto-off state machine.
// Define ALARM_SNOOZE_EN to build in the SNOOZE state, snooze input handling and snooze counter.
module multi_alarm_clock_core #(
    parameter int unsigned NUM_ALARMS = 4,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_MIN   = 2,
    localparam int unsigned AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sec_tick,
    input  logic [1:0]            mode,
    input  logic                  field,
    input  logic [AW-1:0]         alarm_sel,
    input  logic                  up,
    input  logic                  down,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  stop,
    output logic [1:0]            disp_h1,
    output logic [3:0]            disp_h2,
    output logic [2:0]            disp_m1,
    output logic [3:0]            disp_m2,
    output logic [6:0]            sec_bcd,
    output logic                  ringing,
    output logic                  snoozing,
    output logic [AW-1:0]         ring_id
);

    localparam logic [1:0] MODE_SET_TIME  = 2'd1;
    localparam logic [1:0] MODE_SET_ALARM = 2'd2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
`ifdef ALARM_SNOOZE_EN
    localparam logic [1:0] ST_SNOOZE = 2'd2;
`endif

    // BCD step helpers: minutes/seconds are {tens[2:0],ones[3:0]}, hours {tens[1:0],ones[3:0]}
    function automatic logic [6:0] inc60(input logic [6:0] v);
        if (v == 7'h59)       return 7'h00;
        if (v[3:0] == 4'd9)   return {3'(v[6:4] + 3'd1), 4'd0};
        return {v[6:4], 4'(v[3:0] + 4'd1)};
    endfunction

    function automatic logic [6:0] dec60(input logic [6:0] v);
        if (v == 7'h00)       return 7'h59;
        if (v[3:0] == 4'd0)   return {3'(v[6:4] - 3'd1), 4'd9};
        return {v[6:4], 4'(v[3:0] - 4'd1)};
    endfunction

    function automatic logic [5:0] inc24(input logic [5:0] v);
        if (v == 6'h23)       return 6'h00;
        if (v[3:0] == 4'd9)   return {2'(v[5:4] + 2'd1), 4'd0};
        return {v[5:4], 4'(v[3:0] + 4'd1)};
    endfunction

    function automatic logic [5:0] dec24(input logic [5:0] v);
        if (v == 6'h00)       return 6'h23;
        if (v[3:0] == 4'd0)   return {2'(v[5:4] - 2'd1), 4'd9};
        return {v[5:4], 4'(v[3:0] - 4'd1)};
    endfunction

    function automatic logic [6:0] adj60(input logic [6:0] v, input logic u, input logic d);
        if (u && !d) return inc60(v);
        if (d && !u) return dec60(v);
        return v;
    endfunction

    function automatic logic [5:0] adj24(input logic [5:0] v, input logic u, input logic d);
        if (u && !d) return inc24(v);
        if (d && !u) return dec24(v);
        return v;
    endfunction

    logic [6:0]    sec_q, sec_n, min_q, min_n;
    logic [5:0]    hr_q, hr_n;
    logic [6:0]    al_min_q [NUM_ALARMS];
    logic [6:0]    al_min_n [NUM_ALARMS];
    logic [5:0]    al_hr_q  [NUM_ALARMS];
    logic [5:0]    al_hr_n  [NUM_ALARMS];
    logic [1:0]    state_q, state_n;
    logic [3:0]    ring_cnt_q, ring_cnt_n;
    logic [AW-1:0] ring_id_q, ring_id_n;
    logic [5:0]    disp_hr_n;
    logic [6:0]    disp_min_n;
    logic          set_time, set_alarm, mb, match, en_cur;
    logic [AW-1:0] match_id;
`ifdef ALARM_SNOOZE_EN
    logic [3:0]    snz_cnt_q, snz_cnt_n;
`else
    logic [3:0]    unused_cfg;
    assign unused_cfg = 4'(SNOOZE_MIN) ^ {3'd0, snooze};
`endif

    assign set_time  = (mode == MODE_SET_TIME);
    assign set_alarm = (mode == MODE_SET_ALARM);

    // Time of day: free-running except in SET_TIME, where it is hand-adjusted with seconds held at 00
    always_comb begin
        sec_n = sec_q;
        min_n = min_q;
        hr_n  = hr_q;
        mb    = 1'b0;
        if (set_time) begin
            sec_n = 7'h00;
            if (field) hr_n  = adj24(hr_q, up, down);
            else       min_n = adj60(min_q, up, down);
        end else if (sec_tick) begin
            sec_n = inc60(sec_q);
            if (sec_q == 7'h59) begin
                mb    = 1'b1;
                min_n = inc60(min_q);
                if (min_q == 7'h59) hr_n = inc24(hr_q);
            end
        end
    end

    // Alarm adjust, lowest-index match against the post-roll time, and display source select
    always_comb begin
        match    = 1'b0;
        match_id = '0;
        en_cur   = 1'b0;
        for (int i = 0; i < int'(NUM_ALARMS); i++) begin
            al_min_n[i] = al_min_q[i];
            al_hr_n[i]  = al_hr_q[i];
            if (set_alarm && (alarm_sel == AW'(i))) begin
                if (field) al_hr_n[i]  = adj24(al_hr_q[i], up, down);
                else       al_min_n[i] = adj60(al_min_q[i], up, down);
            end
            if (ring_id_q == AW'(i)) en_cur = alarm_en[i];
        end
        for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
            if (alarm_en[i] && (al_min_q[i] == min_n) && (al_hr_q[i] == hr_n)) begin
                match    = mb;
                match_id = AW'(i);
            end
        end
        disp_hr_n  = hr_n;
        disp_min_n = min_n;
        if (set_alarm) begin
            disp_hr_n  = '0;
            disp_min_n = '0;
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                if (alarm_sel == AW'(i)) begin
                    disp_hr_n  = al_hr_n[i];
                    disp_min_n = al_min_n[i];
                end
            end
        end
    end

    // Ring state machine next-state
    always_comb begin
        state_n    = state_q;
        ring_cnt_n = ring_cnt_q;
        ring_id_n  = ring_id_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_n  = snz_cnt_q;
`endif
        if (set_time) begin
            state_n = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (match) begin
                        state_n    = ST_RING;
                        ring_id_n  = match_id;
                        ring_cnt_n = 4'(RING_MIN);
                    end
                end
                ST_RING: begin
                    if (!en_cur || stop) begin
                        state_n = ST_IDLE;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze) begin
                        state_n   = ST_SNOOZE;
                        snz_cnt_n = 4'(SNOOZE_MIN);
`endif
                    end else if (mb) begin
                        ring_cnt_n = ring_cnt_q - 4'd1;
                        if (ring_cnt_q <= 4'd1) state_n = ST_IDLE;
                    end
                end
`ifdef ALARM_SNOOZE_EN
                ST_SNOOZE: begin
                    if (!en_cur || stop) begin
                        state_n = ST_IDLE;
                    end else if (mb) begin
                        snz_cnt_n = snz_cnt_q - 4'd1;
                        if (snz_cnt_q <= 4'd1) begin
                            state_n    = ST_RING;
                            ring_cnt_n = 4'(RING_MIN);
                        end
                    end
                end
`endif
                default: state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                al_min_q[i] <= '0;
                al_hr_q[i]  <= '0;
            end
            state_q    <= ST_IDLE;
            ring_cnt_q <= '0;
            ring_id_q  <= '0;
            disp_h1    <= '0;
            disp_h2    <= '0;
            disp_m1    <= '0;
            disp_m2    <= '0;
            sec_bcd    <= '0;
            ringing    <= 1'b0;
            ring_id    <= '0;
        end else begin
            sec_q      <= sec_n;
            min_q      <= min_n;
            hr_q       <= hr_n;
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                al_min_q[i] <= al_min_n[i];
                al_hr_q[i]  <= al_hr_n[i];
            end
            state_q    <= state_n;
            ring_cnt_q <= ring_cnt_n;
            ring_id_q  <= ring_id_n;
            disp_h1    <= disp_hr_n[5:4];
            disp_h2    <= disp_hr_n[3:0];
            disp_m1    <= disp_min_n[6:4];
            disp_m2    <= disp_min_n[3:0];
            sec_bcd    <= sec_n;
            ringing    <= (state_n == ST_RING);
            ring_id    <= ring_id_n;
        end
    end

`ifdef ALARM_SNOOZE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            snz_cnt_q <= '0;
            snoozing  <= 1'b0;
        end else begin
            snz_cnt_q <= snz_cnt_n;
            snoozing  <= (state_n == ST_SNOOZE);
        end
    end
`else
    assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_multi_alarm_clock_core.sv
// Scoreboard bench for multi_alarm_clock_core: a seconds-of-day reference model feeds an
// expectation queue that a monitor drains every cycle; directed checks cover the key scenarios.
module tb_multi_alarm_clock_core;

    localparam int NA = 4;
    localparam int SM = 5;
    localparam int RM = 2;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ_ON = 1'b1;
`else
    localparam bit SNZ_ON = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, sec_tick = 1'b0, field = 1'b0, up = 1'b0, down = 1'b0;
    logic       snooze = 1'b0, stop = 1'b0;
    logic [1:0] mode = 2'd0, alarm_sel = 2'd0;
    logic [3:0] alarm_en = 4'd0;
    logic [1:0] disp_h1;
    logic [3:0] disp_h2, disp_m2;
    logic [2:0] disp_m1;
    logic [6:0] sec_bcd;
    logic       ringing, snoozing;
    logic [1:0] ring_id;

    multi_alarm_clock_core #(.NUM_ALARMS(NA), .SNOOZE_MIN(SM), .RING_MIN(RM)) dut (
        .clk(clk), .rst(rst), .sec_tick(sec_tick), .mode(mode), .field(field),
        .alarm_sel(alarm_sel), .up(up), .down(down), .alarm_en(alarm_en),
        .snooze(snooze), .stop(stop), .disp_h1(disp_h1), .disp_h2(disp_h2),
        .disp_m1(disp_m1), .disp_m2(disp_m2), .sec_bcd(sec_bcd), .ringing(ringing),
        .snoozing(snoozing), .ring_id(ring_id)
    );

    // Reference state: time as seconds-of-day, alarms as minutes-of-day, ring state 0/1/2
    int t_s;
    int am [NA];
    int st, rcnt, scnt, rid;
    logic [23:0] exp_q [$];
    int n_checks = 0;
    int n_pass = 0;

    function automatic logic [23:0] pack(int dm, int s, bit rg, bit sz, int id);
        int h, m;
        h = dm / 60;
        m = dm % 60;
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), rg, sz, 2'(id)};
    endfunction

    function automatic logic [23:0] dut_out();
        return {disp_h1, disp_h2, disp_m1, disp_m2, sec_bcd, ringing, snoozing, ring_id};
    endfunction

    function automatic int adj(int v, int md, bit u, bit d);
        if (u && !d) return (v + 1) % md;
        if (d && !u) return (v + md - 1) % md;
        return v;
    endfunction

    task automatic compare(string name, logic [23:0] got, logic [23:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t: got %h expected %h", name, $time, got, exp);
    endtask

    task automatic model_step();
        int hh, mm, mid, dm;
        int old_am [NA];
        bit mb, en_cur;
        if (rst) begin
            t_s = 0;
            for (int i = 0; i < NA; i++) am[i] = 0;
            st = 0; rcnt = 0; scnt = 0; rid = 0;
            exp_q.push_back(pack(0, 0, 1'b0, 1'b0, 0));
            return;
        end
        mb = 1'b0;
        old_am = am;
        if (mode == 2'd1) begin
            hh = t_s / 3600;
            mm = (t_s / 60) % 60;
            if (field) hh = adj(hh, 24, up, down);
            else       mm = adj(mm, 60, up, down);
            t_s = hh * 3600 + mm * 60;
        end else if (sec_tick) begin
            mb  = (t_s % 60 == 59);
            t_s = (t_s + 1) % 86400;
        end
        if (mode == 2'd2) begin
            hh = am[alarm_sel] / 60;
            mm = am[alarm_sel] % 60;
            if (field) hh = adj(hh, 24, up, down);
            else       mm = adj(mm, 60, up, down);
            am[alarm_sel] = hh * 60 + mm;
        end
        mid = -1;
        if (mb)
            for (int i = NA - 1; i >= 0; i--)
                if (alarm_en[i] && old_am[i] == t_s / 60) mid = i;
        en_cur = alarm_en[rid];
        if (mode == 2'd1) st = 0;
        else case (st)
            0: if (mid >= 0) begin st = 1; rid = mid; rcnt = RM; end
            1: if (!en_cur || stop) st = 0;
               else if (SNZ_ON && snooze) begin st = 2; scnt = SM; end
               else if (mb) begin rcnt--; if (rcnt == 0) st = 0; end
            2: if (!en_cur || stop) st = 0;
               else if (mb) begin scnt--; if (scnt == 0) begin st = 1; rcnt = RM; end end
            default: st = 0;
        endcase
        dm = (mode == 2'd2) ? am[alarm_sel] : t_s / 60;
        exp_q.push_back(pack(dm, t_s % 60, st == 1, st == 2, rid));
    endtask

    // One clock: model consumes the driven inputs, then pulse inputs drop
    task automatic step();
        model_step();
        @(negedge clk);
        rst = 1'b0; sec_tick = 1'b0; up = 1'b0; down = 1'b0; snooze = 1'b0; stop = 1'b0;
    endtask

    task automatic ticks(int n);
        repeat (n) begin sec_tick = 1'b1; step(); end
    endtask

    task automatic dchk(string nm, int dm, int s, bit rg, bit sz);
        compare(nm, dut_out(), pack(dm, s, rg, sz, 0));
    endtask

    // Walk the minutes back to xx:29, then run into the 07:30 alarm
    task automatic ring_up();
        mode = 2'd1; field = 1'b0;
        while (((t_s / 60) % 60) != 29) begin down = 1'b1; step(); end
        mode = 2'd0;
        ticks(60);
    endtask

    initial begin : monitor
        logic [23:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                compare("cycle", dut_out(), e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        @(negedge clk);
        rst = 1'b1; step();
        rst = 1'b1; step();
        dchk("reset", 0, 0, 0, 0);

        ticks(3661);
        dchk("run_3661", 61, 1, 0, 0);

        mode = 2'd1; field = 1'b0;
        down = 1'b1; step();
        dchk("set_min_00", 60, 0, 0, 0);
        down = 1'b1; step();
        dchk("min_wrap_dn", 119, 0, 0, 0);
        up = 1'b1; down = 1'b1; step();
        dchk("up_dn_same", 119, 0, 0, 0);
        field = 1'b1;
        down = 1'b1; step();
        down = 1'b1; step();
        dchk("hr_wrap_dn", 1439, 0, 0, 0);

        mode = 2'd0;
        ticks(59);
        dchk("pre_roll", 1439, 59, 0, 0);
        ticks(1);
        dchk("day_roll", 0, 0, 0, 0);

        mode = 2'd2;
        for (int s = 0; s <= 2; s += 2) begin
            alarm_sel = 2'(s);
            field = 1'b1; repeat (7)  begin up = 1'b1; step(); end
            field = 1'b0; repeat (30) begin up = 1'b1; step(); end
        end
        dchk("alarm2_set", 450, 0, 0, 0);

        mode = 2'd1;
        field = 1'b1; repeat (7)  begin up = 1'b1; step(); end
        field = 1'b0; repeat (29) begin up = 1'b1; step(); end
        mode = 2'd0;
        alarm_en = 4'b0101;
        ticks(59);
        dchk("pre_match", 449, 59, 0, 0);
        ticks(1);
        dchk("ring_match", 450, 0, 1, 0);
        ticks(60);
        dchk("ring_1mb", 451, 0, 1, 0);
        ticks(60);
        dchk("auto_off", 452, 0, 0, 0);

        ring_up();
        dchk("ring_again", 450, 0, 1, 0);
        snooze = 1'b1; step();
`ifdef ALARM_SNOOZE_EN
        dchk("snoozed", 450, 0, 0, 1);
        ticks(299);
        dchk("snooze_mid", 454, 59, 0, 1);
        ticks(1);
        dchk("snooze_end", 455, 0, 1, 0);
        stop = 1'b1; step();
        dchk("stop", 455, 0, 0, 0);
`else
        dchk("snooze_ignored", 450, 0, 1, 0);
        stop = 1'b1; step();
        dchk("stop", 450, 0, 0, 0);
`endif

        ring_up();
        stop = 1'b1; snooze = 1'b1; step();
        dchk("stop_snooze", 450, 0, 0, 0);

        ring_up();
        snooze = 1'b1; step();
        alarm_en = 4'b0100; step();
        dchk("en_clear", 450, 0, 0, 0);
        alarm_en = 4'b0101;

        mode = 2'd2; alarm_sel = 2'd3; field = 1'b1;
        repeat (25) begin up = 1'b1; sec_tick = 1'b1; step(); end
        dchk("alarm3_hr", 60, 25, 0, 0);
        mode = 2'd0; step();
        dchk("back_run", 450, 25, 0, 0);

        repeat (4000) begin
            int r;
            r = int'($urandom % 10);
            mode      = (r < 6) ? 2'd0 : (r == 6) ? 2'd3 : (r == 7) ? 2'd1 : 2'd2;
            rst       = ($urandom % 600) == 0;
            sec_tick  = 1'($urandom % 2);
            field     = 1'($urandom % 2);
            alarm_sel = 2'($urandom % 4);
            up        = ($urandom % 6) == 0;
            down      = ($urandom % 6) == 0;
            snooze    = ($urandom % 12) == 0;
            stop      = ($urandom % 16) == 0;
            if (($urandom % 50) == 0) alarm_en = 4'($urandom);
            step();
        end

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
